sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Shares the single asynchronous 16-bit board SRAM between two bus masters: master 0 (the SLC-3 CPU memory interface) and master 1 (a program loader/debug port). It sits between the masters and the SRAM pins (CE, UB, LB, OE, WE, ADDR, Data). It serialises their requests and sequences the SRAM control strobes with a fixed number of wait states. It returns read data and a one-cycle acknowledge to the granted master.

## Interface
- WAIT_STATES, 1: cycles added to the strobe phase (OE or WE low) beyond the minimum one; legal range 0–15.
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- m0_req, m1_req  in  1  access request, level; sampled only in IDLE.
- m0_we, m1_we  in  1  1 = write, 0 = read; sampled with req.
- m0_addr, m1_addr  in  20  word address; sampled with req.
- m0_wdata, m1_wdata  in  16  write data; sampled with req.
- m0_rdata, m1_rdata  out  16  registered read data; holds until that master's next read completes.
- m0_ack, m1_ack  out  1  one-cycle completion pulse to the granted master.
- CE, UB, LB, OE, WE  out  1  SRAM controls, active low.
- ADDR  out  20  SRAM address, registered.
- Data  inout  16  SRAM data bus; driven only during writes, otherwise high-Z.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - CE/OE/WE/UB/LB all high; Data high-Z.
  - If any req is high, arbitrate, then latch the winner's we/addr/wdata and the grant index into internal registers.
  - Load the wait counter with WAIT_STATES and go to ACCESS.
  - If no req is high, remain in IDLE.
- ACCESS:
  - CE=0, UB=LB=0 (full-word accesses only); ADDR = latched address.
  - Read: OE=0, WE=1, Data high-Z.
  - Write: OE=1, WE=0, Data driven with latched wdata.
  - Counter decrements each cycle. In the cycle where the counter is 0:
    - a read captures Data into the granted master's rdata at that edge;
    - the FSM goes to DONE.
- DONE:
  - CE=0 and OE=1, WE=1.
  - Write: Data is still driven (data hold after WE rises).
  - Granted master's ack = 1 for this cycle only; the other master's ack stays 0.
  - Next state is IDLE unconditionally.
- Request rules:
  - Input changes outside IDLE are ignored; the latched copy is used.
  - A req still high in IDLE starts a new transaction with the then-current we/addr/wdata.
  - A master that wants only one access drops req in the cycle after its ack.
- Arbitration policy is set by the Configuration macro. With a single requester, that requester always wins.
- Bus safety: OE and WE are never low in the same cycle. Data is never driven while OE=0.
- Reset (asynchronous, any state, including mid-ACCESS):
  - FSM → IDLE.
  - CE, UB, LB, OE, WE = 1; ADDR = 0; Data high-Z.
  - m0_ack = m1_ack = 0; m0_rdata = m1_rdata = 0; round-robin pointer → favour master 0.
  - An in-flight transaction is abandoned with no ack. SRAM contents of an interrupted write are undefined.

## Timing
- IDLE sample at cycle t → ACCESS cycles t+1 … t+1+WAIT_STATES → DONE (ack high) at t+2+WAIT_STATES.
- Default WAIT_STATES=1: ack at t+3; OE/WE low for 2 cycles.
- Read data is valid on mN_rdata from the DONE cycle onward, i.e. the same cycle as ack.
- Back-to-back throughput: one transaction per WAIT_STATES+3 cycles (IDLE, ACCESS×(W+1), DONE).
- WAIT_STATES=0: ACCESS lasts 1 cycle; ack at t+2.
- ADDR is stable for the whole ACCESS+DONE window. It changes only on the IDLE→ACCESS edge.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - Round robin over the two masters. When both request in the same IDLE cycle, the master not granted last wins.
  - The pointer updates on every grant.
  - After reset, master 0 wins the first tie.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority; master 0 always wins ties.
  - Master 1 can starve under continuous m0_req.
  - No pointer register exists.

## Test plan
- Reset mid-write:
  - Stimulus: m0 write addr 0x00010, data 0xBEEF. Assert Reset during ACCESS.
  - Required response: WE=1, CE=1 and Data high-Z in the same cycle; no m0_ack; all outputs at reset values.
- Single read, WAIT_STATES=1:
  - Stimulus: SRAM model holds 0x1234 at 0x00003. m0 reads addr 0x00003.
  - Required response: OE low exactly 2 cycles; m0_ack high at t+3; m0_rdata=0x1234; m1_ack stays 0.
- Write then read back, master 1:
  - Stimulus: m1 writes 0xA5C3 to 0xFFFFF, then reads 0xFFFFF.
  - Required response: WE low 2 cycles with Data=0xA5C3 through DONE; m1_rdata=0xA5C3; OE and WE never low together.
- Simultaneous requests, both held high for 4 transactions:
  - With ARB_ROUND_ROBIN_EN: ack order m0, m1, m0, m1.
  - Without: ack order m0, m0, m0, m0.
- Input change during ACCESS:
  - Stimulus: m0 reads 0x00100; m0_addr changes to 0x00200 mid-ACCESS.
  - Required response: ADDR stays 0x00100 until IDLE; data returned is from 0x00100.
- WAIT_STATES=0, back-to-back:
  - Stimulus: m0 req held for 3 reads.
  - Required response: acks at t+2, t+5, t+8; exactly one ack cycle per transaction.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - one master's request/response bus into sram_port_arbiter
interface sram_port_arbiter_if;
   logic        req;
   logic        we;
   logic [19:0] addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        ack;

   modport master (output req, we, addr, wdata, input rdata, ack);
   modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-master arbiter and strobe sequencer for an async 16-bit SRAM
// ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise master 0 has fixed priority.
module sram_port_arbiter #(
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic               clk,
   input  logic               rst,
   sram_port_arbiter_if.slave m0,
   sram_port_arbiter_if.slave m1,
   output logic               ce,
   output logic               ub,
   output logic               lb,
   output logic               oe,
   output logic               we,
   output logic [19:0]        addr,
   inout  wire  [15:0]        data
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t      state;
   logic [3:0]  wait_cnt;
   logic        gnt;
   logic        lat_we;
   logic [15:0] lat_wdata;
   logic        drive;

   logic        sel;
   logic        sel_we;
   logic [19:0] sel_addr;
   logic [15:0] sel_wdata;

`ifdef ARB_ROUND_ROBIN_EN
   logic        rr_ptr;   // master that wins the next tie
`endif

   always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
      if (m0.req && m1.req)
         sel = rr_ptr;
      else
         sel = !m0.req;
`else
      sel = !m0.req;
`endif
      sel_we    = sel ? m1.we    : m0.we;
      sel_addr  = sel ? m1.addr  : m0.addr;
      sel_wdata = sel ? m1.wdata : m0.wdata;
   end

   // Drive enable stays up through DONE to give data hold after WE rises.
   assign data = drive ? lat_wdata : 16'hzzzz;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         gnt       <= 1'b0;
         lat_we    <= 1'b0;
         lat_wdata <= '0;
         drive     <= 1'b0;
         ce        <= 1'b1;
         ub        <= 1'b1;
         lb        <= 1'b1;
         oe        <= 1'b1;
         we        <= 1'b1;
         addr      <= '0;
         m0.ack    <= 1'b0;
         m1.ack    <= 1'b0;
         m0.rdata  <= '0;
         m1.rdata  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         rr_ptr    <= 1'b0;
`endif
      end else begin
         m0.ack <= 1'b0;
         m1.ack <= 1'b0;
         case (state)
            IDLE: begin
               if (m0.req || m1.req) begin
                  state     <= ACCESS;
                  wait_cnt  <= 4'(WAIT_STATES);
                  gnt       <= sel;
                  lat_we    <= sel_we;
                  lat_wdata <= sel_wdata;
                  addr      <= sel_addr;
                  ce        <= 1'b0;
                  ub        <= 1'b0;
                  lb        <= 1'b0;
                  oe        <= sel_we;
                  we        <= !sel_we;
                  drive     <= sel_we;
`ifdef ARB_ROUND_ROBIN_EN
                  rr_ptr    <= !sel;
`endif
               end
            end
            ACCESS: begin
               if (wait_cnt == 4'd0) begin
                  state <= DONE;
                  oe    <= 1'b1;
                  we    <= 1'b1;
                  if (!lat_we) begin
                     if (gnt) m1.rdata <= data;
                     else     m0.rdata <= data;
                  end
                  if (gnt) m1.ack <= 1'b1;
                  else     m0.ack <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            DONE: begin
               state <= IDLE;
               ce    <= 1'b1;
               ub    <= 1'b1;
               lb    <= 1'b1;
               drive <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - self-checking bench for sram_port_arbiter
// Transaction-level model plus directed literal checks; honours ARB_ROUND_ROBIN_EN.
module tb_sram_port_arbiter;
   localparam int W = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fails = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sram_port_arbiter_if m0_bus();
   sram_port_arbiter_if m1_bus();
   logic        ce, ub, lb, oe, we;
   logic [19:0] addr;
   wire  [15:0] data;

   sram_port_arbiter #(.WAIT_STATES(W)) dut (
      .clk(clk), .rst(rst), .m0(m0_bus), .m1(m1_bus),
      .ce(ce), .ub(ub), .lb(lb), .oe(oe), .we(we), .addr(addr), .data(data)
   );

   sram_port_arbiter_if n0_bus();
   sram_port_arbiter_if n1_bus();
   logic        ce1, ub1, lb1, oe1, we1;
   logic [19:0] addr1;
   wire  [15:0] data1;

   sram_port_arbiter #(.WAIT_STATES(0)) dut0 (
      .clk(clk), .rst(rst), .m0(n0_bus), .m1(n1_bus),
      .ce(ce1), .ub(ub1), .lb(lb1), .oe(oe1), .we(we1), .addr(addr1), .data(data1)
   );

   function automatic bit [15:0] dflt(bit [19:0] a);
      return a[15:0] ^ {a[19:16], 12'h5A5};
   endfunction

   // SRAM models
   bit   [15:0] mem     [bit [19:0]];
   bit   [15:0] ref_mem [bit [19:0]];
   logic [15:0] sram_q  = '0;
   logic [15:0] sram_q1 = '0;
   assign data  = (!ce && !oe)   ? sram_q  : 16'hzzzz;
   assign data1 = (!ce1 && !oe1) ? sram_q1 : 16'hzzzz;

   always @(negedge clk) begin
      if (!ce && !we) mem[addr] = data;
      sram_q  = mem.exists(addr) ? mem[addr] : dflt(addr);
      sram_q1 = dflt(addr1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: actual %0h required %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Transaction-level reference: a granted request occupies cycles t .. t+W+2.
   bit        busy;
   int        t_start;
   bit        t_we, t_gnt, last_gnt = 1'b1;
   bit [19:0] t_addr, last_addr;
   bit [15:0] t_wdata, t_rd;
   bit [15:0] exp_rd [2];

   always @(negedge clk) begin : model_chk
      int d;
      bit act_ph, done_ph, was_free, both, win;
      if (rst) begin
         busy = 1'b0; last_addr = '0; exp_rd[0] = '0; exp_rd[1] = '0; last_gnt = 1'b1;
      end else begin
         d       = cyc - t_start;
         act_ph  = busy && d >= 1 && d <= W + 1;
         done_ph = busy && d == W + 2;
         if (done_ph && !t_we) exp_rd[t_gnt] = t_rd;
         check("ce", 32'(ce), (act_ph || done_ph) ? 0 : 1);
         if (!done_ph) check("ublb", 32'({ub, lb}), act_ph ? 0 : 3);
         check("oe", 32'(oe), act_ph ? 32'(t_we) : 1);
         check("we", 32'(we), act_ph ? 32'(!t_we) : 1);
         check("addr", 32'(addr), (busy && d >= 1) ? 32'(t_addr) : 32'(last_addr));
         check("m0_ack", 32'(m0_bus.ack), 32'(done_ph && !t_gnt));
         check("m1_ack", 32'(m1_bus.ack), 32'(done_ph && t_gnt));
         check("m0_rdata", 32'(m0_bus.rdata), 32'(exp_rd[0]));
         check("m1_rdata", 32'(m1_bus.rdata), 32'(exp_rd[1]));
         if ((act_ph || done_ph) && t_we) check("wr_bus", 32'(data), 32'(t_wdata));
         was_free = !busy;
         if (done_ph) begin
            busy = 1'b0;
            last_addr = t_addr;
            if (t_we) ref_mem[t_addr] = t_wdata;
         end
         if (was_free && (m0_bus.req || m1_bus.req)) begin
            both = m0_bus.req && m1_bus.req;
`ifdef ARB_ROUND_ROBIN_EN
            win = both ? !last_gnt : m1_bus.req;
`else
            win = !m0_bus.req;
`endif
            last_gnt = win;
            busy     = 1'b1;
            t_start  = cyc;
            t_gnt    = win;
            t_we     = win ? m1_bus.we    : m0_bus.we;
            t_addr   = win ? m1_bus.addr  : m0_bus.addr;
            t_wdata  = win ? m1_bus.wdata : m0_bus.wdata;
            t_rd     = ref_mem.exists(t_addr) ? ref_mem[t_addr] : dflt(t_addr);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   function automatic bit [19:0] pick_addr();
      int r;
      r = $urandom_range(0, 16);
      return (r == 16) ? 20'hFFFFF : 20'(r);
   endfunction

   initial begin
      int order[$];
      int acks[$];
      int exp_order[4];
      int oe_cnt, we_cnt, ack_at;
      bit m1_seen, clash;

      m0_bus.req = 0; m0_bus.we = 0; m0_bus.addr = '0; m0_bus.wdata = '0;
      m1_bus.req = 0; m1_bus.we = 0; m1_bus.addr = '0; m1_bus.wdata = '0;
      n0_bus.req = 0; n0_bus.we = 0; n0_bus.addr = '0; n0_bus.wdata = '0;
      n1_bus.req = 0; n1_bus.we = 0; n1_bus.addr = '0; n1_bus.wdata = '0;
      repeat (3) step();
      check("rst_ctrl", 32'({ce, ub, lb, oe, we}), 32'h1F);
      check("rst_addr", 32'(addr), 0);
      check("rst_acks", 32'({m0_bus.ack, m1_bus.ack}), 0);
      check("rst_rdata", 32'({m0_bus.rdata, m1_bus.rdata}), 0);
      rst = 1'b0;
      repeat (2) step();

      // reset in the middle of a write
      m0_bus.req = 1; m0_bus.we = 1; m0_bus.addr = 20'h00010; m0_bus.wdata = 16'hBEEF;
      step();
      m0_bus.req = 0;
      check("rmw_we_low", 32'(we), 0);
      rst = 1'b1;
      #1;
      check("rmw_we", 32'(we), 1);
      check("rmw_ce", 32'(ce), 1);
      check("rmw_oe", 32'(oe), 1);
      check("rmw_addr", 32'(addr), 0);
      check("rmw_ack", 32'(m0_bus.ack), 0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("rmw_no_ack", 32'(m0_bus.ack), 0);
      end

      // simultaneous requests held for four transactions
`ifdef ARB_ROUND_ROBIN_EN
      exp_order = '{0, 1, 0, 1};
`else
      exp_order = '{0, 0, 0, 0};
`endif
      m0_bus.req = 1; m0_bus.we = 0; m0_bus.addr = 20'h00001;
      m1_bus.req = 1; m1_bus.we = 0; m1_bus.addr = 20'h00002;
      for (int i = 0; i < 40 && order.size() < 4; i++) begin
         step();
         if (m0_bus.ack) order.push_back(0);
         if (m1_bus.ack) order.push_back(1);
      end
      m0_bus.req = 0; m1_bus.req = 0;
      check("tie_count", 32'(order.size()), 4);
      for (int i = 0; i < 4 && i < order.size(); i++)
         check("tie_order", 32'(order[i]), 32'(exp_order[i]));
      repeat (3) step();

      // single read, W=1
      mem[20'h00003] = 16'h1234; ref_mem[20'h00003] = 16'h1234;
      m0_bus.req = 1; m0_bus.we = 0; m0_bus.addr = 20'h00003;
      oe_cnt = 0; ack_at = -1; m1_seen = 0;
      for (int i = 1; i <= 6; i++) begin
         step();
         if (i == 1) m0_bus.req = 0;
         if (!oe) oe_cnt++;
         if (m0_bus.ack && ack_at < 0) ack_at = i;
         if (m1_bus.ack) m1_seen = 1;
      end
      check("rd_oe_cycles", 32'(oe_cnt), 2);
      check("rd_ack_at", 32'(ack_at), 3);
      check("rd_data", 32'(m0_bus.rdata), 32'h1234);
      check("rd_m1_ack", 32'(m1_seen), 0);

      // master 1 write then read back at the top address
      m1_bus.req = 1; m1_bus.we = 1; m1_bus.addr = 20'hFFFFF; m1_bus.wdata = 16'hA5C3;
      we_cnt = 0; clash = 0;
      for (int i = 1; i <= 5; i++) begin
         step();
         if (i == 1) m1_bus.req = 0;
         if (!we) we_cnt++;
         if (!we && !oe) clash = 1;
         if (i == 3) check("wr_hold_data", 32'(data), 32'hA5C3);
      end
      check("wr_we_cycles", 32'(we_cnt), 2);
      m1_bus.req = 1; m1_bus.we = 0;
      for (int i = 1; i <= 5; i++) begin
         step();
         if (i == 1) m1_bus.req = 0;
         if (!we && !oe) clash = 1;
      end
      check("wr_readback", 32'(m1_bus.rdata), 32'hA5C3);
      check("wr_oe_we_clash", 32'(clash), 0);

      // request inputs change mid-access
      mem[20'h00100] = 16'h7777; ref_mem[20'h00100] = 16'h7777;
      mem[20'h00200] = 16'h8888; ref_mem[20'h00200] = 16'h8888;
      m0_bus.req = 1; m0_bus.we = 0; m0_bus.addr = 20'h00100;
      for (int i = 1; i <= 4; i++) begin
         step();
         if (i == 1) begin m0_bus.req = 0; m0_bus.addr = 20'h00200; end
         check("hold_addr", 32'(addr), 32'h00100);
      end
      check("hold_rdata", 32'(m0_bus.rdata), 32'h7777);

      // zero wait states, back-to-back reads
      n0_bus.req = 1; n0_bus.we = 0; n0_bus.addr = 20'h00007;
      for (int i = 1; i <= 12; i++) begin
         step();
         if (n0_bus.ack) acks.push_back(i);
         if (i == 9) n0_bus.req = 0;
      end
      check("ws0_ack_count", 32'(acks.size()), 3);
      if (acks.size() >= 3) begin
         check("ws0_ack0", 32'(acks[0]), 2);
         check("ws0_ack1", 32'(acks[1]), 5);
         check("ws0_ack2", 32'(acks[2]), 8);
      end
      check("ws0_rdata", 32'(n0_bus.rdata), 32'(dflt(20'h00007)));

      // randomized traffic against the model
      repeat (1500) begin
         step();
         m0_bus.req   = ($urandom_range(0, 3) != 0);
         m0_bus.we    = 1'($urandom_range(0, 1));
         m0_bus.addr  = pick_addr();
         m0_bus.wdata = 16'($urandom);
         m1_bus.req   = ($urandom_range(0, 2) != 0);
         m1_bus.we    = 1'($urandom_range(0, 1));
         m1_bus.addr  = pick_addr();
         m1_bus.wdata = 16'($urandom);
      end
      m0_bus.req = 0; m1_bus.req = 0;
      repeat (6) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
